// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state type, bus field widths and the
// address-acceptance rule used by the target.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX_BYTE  = 3'd3,
    RX_ACK   = 3'd4,
    TX_BYTE  = 3'd5,
    TX_ACK   = 3'd6
  } i2c_state_t;

  // True when a received 7-bit address selects this target. General call
  // (address 0) and the 10-bit addressing prefix 11110xx are never accepted.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] own);
    return (addr == own) && (addr != '0) && (addr[6:2] != 5'b11110);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer followed by an edge register for one I2C line.
// All flops reset to 1 (idle bus) so no spurious edge follows reset.
// rise/fall, level and prev all describe the same pair of samples and
// appear three clk edges after the pin changes.
module i2c_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic prev,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;

  // Synchronize the pin, then register the current/previous sample and edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      level <= sync2;
      prev  <= level;
      rise  <= sync2 & ~level;
      fall  <= ~sync2 & level;
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target (7-bit addressing, no clock stretching). Receives bytes on
// master writes and returns tx_data on master reads. sda is open-drain:
// only ever driven low or released. The FSM state is exported on 'state'.
//
// Pulse outputs: tx_req, rx_valid, start_det and stop_det are single-clk
// strobes with no back-pressure. tx_data is captured on the same clk that
// tx_req is high, so the source may advance to its next byte afterwards;
// rx_data is valid whenever rx_valid is high and holds until the next byte.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h42
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  inout  tri                sda,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_req,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              start_det,
  output logic              stop_det,
  output i2c_state_t        state
);

  logic scl_level, scl_prev, scl_rise, scl_fall;
  logic sda_level, sda_prev_unused, sda_rise, sda_fall;

  logic              drive_low;
  logic [DATA_W-1:0] shifter;
  logic [2:0]        bit_cnt;
  logic              ack_seen;

  logic              start_cond;
  logic              stop_cond;
  logic [DATA_W-1:0] next_byte;

  i2c_sync_edge u_scl_sync (
    .clk   (clk),
    .reset (reset),
    .din   (scl),
    .level (scl_level),
    .prev  (scl_prev),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sda),
    .level (sda_level),
    .prev  (sda_prev_unused),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // Open-drain pad: pull low or release.
  assign sda = drive_low ? 1'b0 : 1'bz;

  // Bus conditions need scl stable high across both samples of the sda edge.
  assign start_cond = sda_fall && scl_level && scl_prev;
  assign stop_cond  = sda_rise && scl_level && scl_prev;
  assign next_byte  = {shifter[DATA_W-2:0], sda_level};

  // Protocol FSM: bits are sampled on scl rise, the sda drive changes on scl
  // fall. In the ACK states the first scl fall starts our ACK bit and the
  // second one ends it, which drive_low distinguishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drive_low <= 1'b0;
      shifter   <= '0;
      bit_cnt   <= 3'd0;
      ack_seen  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      tx_req    <= 1'b0;
      rx_valid  <= 1'b0;
      start_det <= start_cond;
      stop_det  <= stop_cond;
      if (start_cond) begin
        // A (repeated) START abandons any partial byte and re-addresses.
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        shifter   <= '0;
        drive_low <= 1'b0;
        ack_seen  <= 1'b0;
      end else if (stop_cond) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        shifter   <= '0;
        drive_low <= 1'b0;
        ack_seen  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            drive_low <= 1'b0;
          end
          ADDR: begin
            if (scl_rise) begin
              shifter <= next_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (addr_ok(next_byte[DATA_W-1:1], SLAVE_ADDR)) begin
                  state <= ADDR_ACK;
                  busy  <= 1'b1;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!drive_low) begin
                drive_low <= 1'b1;
              end else if (shifter[0]) begin
                // Read: first data MSB goes out as the ACK bit ends.
                shifter   <= tx_data;
                tx_req    <= 1'b1;
                drive_low <= ~tx_data[DATA_W-1];
                state     <= TX_BYTE;
              end else begin
                drive_low <= 1'b0;
                state     <= RX_BYTE;
              end
            end
          end
          RX_BYTE: begin
            if (scl_rise) begin
              shifter <= next_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= next_byte;
                rx_valid <= 1'b1;
                state    <= RX_ACK;
              end
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              if (!drive_low) begin
                drive_low <= 1'b1;
              end else begin
                drive_low <= 1'b0;
                state     <= RX_BYTE;
              end
            end
          end
          TX_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              // bit_cnt has wrapped to 0 after the 8th rise: byte is done.
              if (bit_cnt == 3'd0) begin
                drive_low <= 1'b0;
                ack_seen  <= 1'b0;
                state     <= TX_ACK;
              end else begin
                shifter   <= {shifter[DATA_W-2:0], 1'b0};
                drive_low <= ~shifter[DATA_W-2];
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (sda_level) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                ack_seen <= 1'b1;
              end
            end else if (scl_fall && ack_seen) begin
              shifter   <= tx_data;
              tx_req    <= 1'b1;
              drive_low <= ~tx_data[DATA_W-1];
              ack_seen  <= 1'b0;
              state     <= TX_BYTE;
            end
          end
          default: begin
            state     <= IDLE;
            drive_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master on an open-drain bus,
// a table of write transactions plus hand-written read, repeated-START,
// abort and reset sequences.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 8;  // clk cycles per quarter scl period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- bus and DUT ----------------
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda_line;
  pullup (sda_line);
  assign sda_line = m_low ? 1'b0 : 1'bz;

  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       tx_req, rx_valid, busy, start_det, stop_det;
  i2c_state_t state;

  logic [7:0] tx_tab [64];

  i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda_line),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .start_det (start_det),
    .stop_det  (stop_det),
    .state     (state)
  );

  // ---------------- monitor (event counters / logs) ----------------
  int rx_cnt = 0;
  int txreq_cnt = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int drive_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] rx_log [64];

  assign tx_data = tx_tab[txreq_cnt[5:0]];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[5:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_req)    txreq_cnt <= txreq_cnt + 1;
    if (start_det) start_cnt <= start_cnt + 1;
    if (stop_det)  stop_cnt  <= stop_cnt + 1;
    if (busy)      busy_cnt  <= busy_cnt + 1;
    if (sda_line == 1'b0 && !m_low) drive_cnt <= drive_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_rx(input string name, input int base);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s rx byte %0d", name, i), rx_log[(base + i) % 64], e);
    end
  endtask

  // ---------------- master driver tasks ----------------
  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic start_bit();
    m_low = 1'b1; wq(); scl = 1'b0;
  endtask

  task automatic rstart_bit();
    wq(); m_low = 1'b0; wq(); scl = 1'b1; wq(); m_low = 1'b1; wq(); scl = 1'b0;
  endtask

  task automatic stop_bit();
    wq(); m_low = 1'b1; wq(); scl = 1'b1; wq(); m_low = 1'b0; wq();
  endtask

  task automatic write_bit(input logic b);
    wq(); m_low = ~b; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wq(); m_low = 1'b0; wq(); scl = 1'b1; wq(); b = sda_line; wq(); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~send_ack);
  endtask

  // ---------------- write-transaction table ----------------
  typedef struct {
    logic [7:0]      addr_byte;
    int              nbytes;
    logic [1:0][7:0] data;
    logic            exp_ack;
  } wr_vec_t;

  wr_vec_t vecs [5];

  // ---------------- test sequence ----------------
  initial begin
    logic       ack;
    logic [7:0] d;
    int rx0, st0, sp0, dr0, bz0, tq0, k;

    for (int i = 0; i < 64; i++) tx_tab[i] = 8'h00;

    vecs[0] = '{addr_byte: 8'h84, nbytes: 2, data: {8'h3C, 8'hA5}, exp_ack: 1'b1};
    vecs[1] = '{addr_byte: 8'h86, nbytes: 0, data: {8'h00, 8'h00}, exp_ack: 1'b0};
    vecs[2] = '{addr_byte: 8'h00, nbytes: 0, data: {8'h00, 8'h00}, exp_ack: 1'b0};
    vecs[3] = '{addr_byte: 8'h84, nbytes: 2, data: {8'h00, 8'hFF}, exp_ack: 1'b1};
    vecs[4] = '{addr_byte: 8'hF0, nbytes: 0, data: {8'h00, 8'h00}, exp_ack: 1'b0};

    // Reset state
    repeat (5) @(negedge clk);
    check("reset state", state, IDLE);
    check("reset busy", busy, 1'b0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset tx_req", tx_req, 1'b0);
    check("reset start_det", start_det, 1'b0);
    check("reset stop_det", stop_det, 1'b0);
    check("reset sda released", sda_line, 1'b1);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post-reset no start", start_cnt, 0);

    // Table-driven write transactions
    for (int v = 0; v < 5; v++) begin
      rx0 = rx_cnt; st0 = start_cnt; sp0 = stop_cnt; dr0 = drive_cnt; bz0 = busy_cnt;
      start_bit();
      write_byte(vecs[v].addr_byte, ack);
      check($sformatf("v%0d addr ack", v), ack, vecs[v].exp_ack);
      if (vecs[v].exp_ack) begin
        check($sformatf("v%0d busy after match", v), busy, 1'b1);
        for (int i = 0; i < vecs[v].nbytes; i++) begin
          exp_q.push_back(vecs[v].data[i]);
          write_byte(vecs[v].data[i], ack);
          check($sformatf("v%0d data ack %0d", v, i), ack, 1'b1);
        end
        check($sformatf("v%0d busy before stop", v), busy, 1'b1);
      end
      stop_bit();
      repeat (8) @(negedge clk);
      check($sformatf("v%0d busy after stop", v), busy, 1'b0);
      check($sformatf("v%0d state idle", v), state, IDLE);
      check($sformatf("v%0d start pulses", v), start_cnt - st0, 1);
      check($sformatf("v%0d stop pulses", v), stop_cnt - sp0, 1);
      check($sformatf("v%0d rx count", v), rx_cnt - rx0, vecs[v].exp_ack ? vecs[v].nbytes : 0);
      if (!vecs[v].exp_ack) begin
        check($sformatf("v%0d sda never driven", v), drive_cnt - dr0, 0);
        check($sformatf("v%0d busy never high", v), busy_cnt - bz0, 0);
      end
      check_rx($sformatf("v%0d", v), rx0);
    end

    // Read: 0x5A with master ACK, then 0xF0 with master NACK
    k = txreq_cnt; tq0 = txreq_cnt;
    tx_tab[k % 64] = 8'h5A;
    tx_tab[(k + 1) % 64] = 8'hF0;
    start_bit();
    write_byte(8'h85, ack);
    check("read addr ack", ack, 1'b1);
    read_byte(1'b1, d);
    check("read byte 0", d, 8'h5A);
    read_byte(1'b0, d);
    check("read byte 1", d, 8'hF0);
    repeat (4) @(negedge clk);
    check("read state after nack", state, IDLE);
    check("read busy after nack", busy, 1'b0);
    check("read tx_req pulses", txreq_cnt - tq0, 2);
    stop_bit();
    repeat (8) @(negedge clk);

    // Repeated START: write 0x11, Sr, read one byte
    rx0 = rx_cnt; st0 = start_cnt;
    start_bit();
    write_byte(8'h84, ack);
    check("rs addr w ack", ack, 1'b1);
    exp_q.push_back(8'h11);
    write_byte(8'h11, ack);
    check("rs data ack", ack, 1'b1);
    k = txreq_cnt; tq0 = txreq_cnt;
    tx_tab[k % 64] = 8'h96;
    rstart_bit();
    write_byte(8'h85, ack);
    check("rs re-address ack", ack, 1'b1);
    read_byte(1'b0, d);
    check("rs read byte", d, 8'h96);
    stop_bit();
    repeat (8) @(negedge clk);
    check("rs rx count", rx_cnt - rx0, 1);
    check("rs start pulses", start_cnt - st0, 2);
    check("rs tx_req pulses", txreq_cnt - tq0, 1);
    check_rx("rs", rx0);

    // Abort: STOP after 4 bits of a data byte
    rx0 = rx_cnt;
    start_bit();
    write_byte(8'h84, ack);
    check("abort addr ack", ack, 1'b1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    stop_bit();
    repeat (8) @(negedge clk);
    check("abort rx count", rx_cnt - rx0, 0);
    check("abort state", state, IDLE);
    check("abort busy", busy, 1'b0);

    // Reset while driving a 0 data bit in TX_BYTE
    k = txreq_cnt;
    tx_tab[k % 64] = 8'h00;
    tx_tab[(k + 1) % 64] = 8'h00;
    start_bit();
    write_byte(8'h85, ack);
    check("rst addr ack", ack, 1'b1);
    repeat (10) @(negedge clk);
    check("rst state tx_byte", state, TX_BYTE);
    check("rst sda driven low", sda_line, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst sda released", sda_line, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    check("rst state idle", state, IDLE);
    check("rst busy", busy, 1'b0);
    stop_bit();
    repeat (8) @(negedge clk);
    rx0 = rx_cnt;
    start_bit();
    write_byte(8'h84, ack);
    check("rst rewrite addr ack", ack, 1'b1);
    exp_q.push_back(8'hC3);
    write_byte(8'hC3, ack);
    check("rst rewrite data ack", ack, 1'b1);
    stop_bit();
    repeat (8) @(negedge clk);
    check("rst rewrite rx count", rx_cnt - rx0, 1);
    check_rx("rst rewrite", rx0);
    check("rst rewrite rx_data hold", rx_data, 8'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
